multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Sequencing controller for the multi-cycle build of the RV32I core. It replaces the single-cycle control unit and steps the shared datapath (one memory port, one ALU, IR/OldPC/ALUOut/Data registers) through fetch, decode, execute, memory and writeback for each instruction. It waits on a memory-ready handshake and traps unsupported opcodes. It contains the main decoder as a Moore FSM and the ALU decoder as combinational logic.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset; one clock; the reset is synchronous and active-high
- Op  in  7  instruction[6:0] from IR
- funct3  in  3  instruction[14:12]
- funct7  in  7  instruction[31:25]
- Zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completed the current access this cycle
- PCWrite  out  1  load PC
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load IR and OldPC
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J (decoded from Op, independent of state)
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  out  1  one-cycle pulse on every transition into FETCH
- illegal  out  1  high while in ERROR

## Operation
- State register is 4 bits. Outputs are Moore in state, except that PCWrite also depends on Zero and mem_ready, and IRWrite on mem_ready. Any output not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - mem_ready → DECODE; otherwise stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jump target). Next state by Op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other opcode → ERROR
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Op[5]=0 → MEMREAD; Op[5]=1 → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. mem_ready → MEMWB; otherwise hold.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays high while waiting. mem_ready → FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 → ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero → FETCH.
- ERROR: illegal=1, all enables 0. Absorbing state; exited only by rst.
- ALU decoder (ALUOp is internal, 2 bits):
  - ALUOp 00 → 000; 01 → 001.
  - ALUOp 10, by funct3:
    - 000: sub (001) if Op[5] & funct7[5], else add (000)
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - other → 000
  - ALUOp 11 → 000.

## Timing
- Reset: at the clock edge with rst=1, state becomes FETCH and instr_done is cleared.
  - While rst is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 combinationally; illegal=0.
  - After rst is released, the first fetch begins in the next cycle.
  - rst in any state, including a stalled MEMWRITE or ERROR, aborts that state with no further enables.
- instr_done is registered: high for exactly the one cycle after any transition into FETCH. It is not asserted out of reset.
- Instruction latency with mem_ready tied high: R/I-type 4 cycles, lw 5, sw 4, beq 3, jal 4.
- Each cycle with mem_ready low in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs are held steady while stalled.
- mem_ready is ignored in every other state.
- Zero is sampled only in BEQ, combinationally.

## Test plan
- rst for 1 cycle, mem_ready=1, add (Op=0110011, funct3=000, funct7=0): states FETCH, DECODE, EXECUTER, ALUWB. RegWrite=1 only in cycle 4, ALUControl=000 in cycle 3, instr_done high in cycle 5.
- sub (funct7=0100000) → ALUControl=001 in EXECUTER; addi with funct7[5]=1 (Op=0010011) → ALUControl=000.
- lw with mem_ready low for 2 cycles in MEMREAD: AdrSrc=1 for 3 cycles, then MEMWB with ResultSrc=01, RegWrite=1; total 7 cycles.
- beq with Zero=1 → PCWrite=1 in cycle 3, ALUControl=001. Same with Zero=0 → PCWrite=0. Both return to FETCH.
- Op=1111111 → ERROR: illegal=1 indefinitely, no enables. Assert rst → FETCH, illegal=0.
- sw with mem_ready=0 in MEMWRITE, rst asserted mid-stall → MemWrite drops in the same cycle, state is FETCH after the edge, and instr_done is not pulsed.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Sequencing controller for the multi-cycle RV32I core. Steps
//                the shared datapath through fetch, decode, execute, memory
//                and writeback, stalls on the memory-ready handshake and
//                traps unsupported opcodes in an absorbing error state.
//                Main decoder is a Moore FSM; the ALU decoder is combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] c_st_fetch    = 4'd0;
    localparam logic [3:0] c_st_decode   = 4'd1;
    localparam logic [3:0] c_st_memadr   = 4'd2;
    localparam logic [3:0] c_st_memread  = 4'd3;
    localparam logic [3:0] c_st_memwb    = 4'd4;
    localparam logic [3:0] c_st_memwrite = 4'd5;
    localparam logic [3:0] c_st_executer = 4'd6;
    localparam logic [3:0] c_st_executei = 4'd7;
    localparam logic [3:0] c_st_aluwb    = 4'd8;
    localparam logic [3:0] c_st_jal      = 4'd9;
    localparam logic [3:0] c_st_beq      = 4'd10;
    localparam logic [3:0] c_st_error    = 4'd11;

    // Supported opcodes
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_rtype = 7'b0110011;
    localparam logic [6:0] c_op_itype = 7'b0010011;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_beq   = 7'b1100011;

    // Internal ALU operation class handed from main decoder to ALU decoder
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // ALUControl codes
    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b101;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_instr_done;

    // Moore outputs before the reset gate on the write enables
    logic       w_pcwrite;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_adrsrc;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;

    // Next-state selection; only the wait states look at mem_ready
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_fetch: begin
                if (mem_ready) w_next = c_st_decode;
            end
            c_st_decode: begin
                case (Op)
                    c_op_load,
                    c_op_store: w_next = c_st_memadr;
                    c_op_rtype: w_next = c_st_executer;
                    c_op_itype: w_next = c_st_executei;
                    c_op_jal:   w_next = c_st_jal;
                    c_op_beq:   w_next = c_st_beq;
                    default:    w_next = c_st_error;
                endcase
            end
            c_st_memadr: begin
                w_next = Op[5] ? c_st_memwrite : c_st_memread;
            end
            c_st_memread: begin
                if (mem_ready) w_next = c_st_memwb;
            end
            c_st_memwb:    w_next = c_st_fetch;
            c_st_memwrite: begin
                if (mem_ready) w_next = c_st_fetch;
            end
            c_st_executer: w_next = c_st_aluwb;
            c_st_executei: w_next = c_st_aluwb;
            c_st_aluwb:    w_next = c_st_fetch;
            c_st_jal:      w_next = c_st_aluwb;
            c_st_beq:      w_next = c_st_fetch;
            c_st_error:    w_next = c_st_error;
            default:       w_next = c_st_error;
        endcase
    end

    // State register and the completion pulse on every entry into fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_fetch;
            r_instr_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_instr_done <= (w_next == c_st_fetch) && (r_state != c_st_fetch);
        end
    end

    // Per-state datapath controls; anything not named for a state stays 0
    always_comb begin
        w_pcwrite   = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_adrsrc    = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = c_aluop_add;
        case (r_state)
            c_st_fetch: begin
                // PC+4 is computed and written back together with the IR
                w_alusrca   = 2'b00;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_irwrite   = mem_ready;
                w_pcwrite   = mem_ready;
            end
            c_st_decode: begin
                // Branch/jump target computed speculatively from OldPC
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
            end
            c_st_memadr: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
            end
            c_st_memread: begin
                w_adrsrc    = 1'b1;
                w_resultsrc = 2'b00;
            end
            c_st_memwb: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            c_st_memwrite: begin
                // Strobe is held for the whole access, including stalls
                w_adrsrc    = 1'b1;
                w_resultsrc = 2'b00;
                w_memwrite  = 1'b1;
            end
            c_st_executer: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b00;
                w_aluop   = c_aluop_funct;
            end
            c_st_executei: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = c_aluop_funct;
            end
            c_st_aluwb: begin
                w_resultsrc = 2'b00;
                w_regwrite  = 1'b1;
            end
            c_st_jal: begin
                // Link value PC+4 from OldPC while PC takes the target in ALUOut
                w_alusrca   = 2'b01;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b00;
                w_pcwrite   = 1'b1;
            end
            c_st_beq: begin
                w_alusrca   = 2'b10;
                w_alusrcb   = 2'b00;
                w_aluop     = c_aluop_sub;
                w_resultsrc = 2'b00;
                w_pcwrite   = Zero;
            end
            default: begin
            end
        endcase
    end

    // ALU decoder: operation class plus funct fields to ALU function
    always_comb begin
        ALUControl = c_alu_add;
        case (w_aluop)
            c_aluop_add: ALUControl = c_alu_add;
            c_aluop_sub: ALUControl = c_alu_sub;
            c_aluop_funct: begin
                case (funct3)
                    3'b000:  ALUControl = (Op[5] & funct7[5]) ? c_alu_sub : c_alu_add;
                    3'b010:  ALUControl = c_alu_slt;
                    3'b110:  ALUControl = c_alu_or;
                    3'b111:  ALUControl = c_alu_and;
                    default: ALUControl = c_alu_add;
                endcase
            end
            default: ALUControl = c_alu_add;
        endcase
    end

    // Immediate format follows the opcode alone, independent of state
    always_comb begin
        ImmSrc = 2'b00;
        case (Op)
            c_op_store: ImmSrc = 2'b01;
            c_op_beq:   ImmSrc = 2'b10;
            c_op_jal:   ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

    // Reset kills every write enable and the trap flag in the same cycle
    assign PCWrite    = w_pcwrite  & ~rst;
    assign IRWrite    = w_irwrite  & ~rst;
    assign MemWrite   = w_memwrite & ~rst;
    assign RegWrite   = w_regwrite & ~rst;
    assign illegal    = (r_state == c_st_error) & ~rst;
    assign AdrSrc     = w_adrsrc;
    assign ResultSrc  = w_resultsrc;
    assign ALUSrcA    = w_alusrca;
    assign ALUSrcB    = w_alusrcb;
    assign instr_done = r_instr_done;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_fsm
//  Description : Self-checking bench for multicycle_control_fsm. Each
//                instruction is expanded into its expected per-cycle control
//                trace, then replayed cycle by cycle against the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control_fsm;

    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_rtype = 7'b0110011;
    localparam logic [6:0] c_op_itype = 7'b0010011;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_beq   = 7'b1100011;

    logic       clk;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       instr_done, illegal;

    multicycle_control_fsm u_dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and its expected packed outputs
    typedef struct packed {
        logic        rst;
        logic        mr;
        logic        z;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [17:0] exp;
    } step_t;

    step_t      q[$];
    int         n_total;
    int         n_bad;
    logic       after_reset;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == c_op_store) return 2'b01;
        if (op == c_op_beq)   return 2'b10;
        if (op == c_op_jal)   return 2'b11;
        return 2'b00;
    endfunction

    // Arithmetic instruction to ALU function (subtract only in register form)
    function automatic logic [2:0] alu_of(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'b000:  return (op == c_op_rtype && f7[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic done, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm_of(cur_op), ac, done, ill};
    endfunction

    task automatic push(input logic r, input logic mr, input logic z, input logic [17:0] exp);
        step_t s;
        s.rst = r; s.mr = mr; s.z = z;
        s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7;
        s.exp = exp;
        q.push_back(s);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic fetch_decode(input int fs);
        for (int s = 0; s <= fs; s++) begin
            logic mr;
            mr = (s == fs);
            push(1'b0, mr, rb(), mk(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 3'b000,
                                   (s == 0) && !after_reset, 0));
        end
        after_reset = 1'b0;
        push(1'b0, rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0));
    endtask

    // Expand one instruction into its cycle trace
    task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int fs, input int ms, input logic z, input int err_cycles);
        cur_op = op; cur_f3 = f3; cur_f7 = f7;
        fetch_decode(fs);
        case (op)
            c_op_load, c_op_store: begin
                push(1'b0, rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));
                for (int s = 0; s <= ms; s++) begin
                    logic mr;
                    mr = (s == ms);
                    push(1'b0, mr, rb(), mk(0, 1, (op == c_op_store), 0, 0, 2'b00, 2'b00, 2'b00,
                                           3'b000, 0, 0));
                end
                if (op == c_op_load)
                    push(1'b0, rb(), rb(), mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0));
            end
            c_op_rtype, c_op_itype: begin
                push(1'b0, rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10,
                                         (op == c_op_itype) ? 2'b01 : 2'b00, alu_of(op, f3, f7), 0, 0));
                push(1'b0, rb(), rb(), mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
            end
            c_op_jal: begin
                push(1'b0, rb(), rb(), mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0));
                push(1'b0, rb(), rb(), mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
            end
            c_op_beq: begin
                push(1'b0, rb(), z, mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 0));
            end
            default: begin
                for (int k = 0; k < err_cycles; k++)
                    push(1'b0, rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1));
                push(1'b1, rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
                after_reset = 1'b1;
            end
        endcase
    endtask

    // Store stalled in memory write, then reset lands during the stall
    task automatic add_sw_reset();
        cur_op = c_op_store; cur_f3 = 3'b010; cur_f7 = 7'h00;
        fetch_decode(0);
        push(1'b0, rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));
        push(1'b0, 1'b0, rb(), mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        push(1'b1, 1'b0, rb(), mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        after_reset = 1'b1;
    endtask

    initial begin
        logic [6:0] legal_ops [6];
        n_total = 0;
        n_bad   = 0;
        after_reset = 1'b1;
        legal_ops[0] = c_op_load;  legal_ops[1] = c_op_store; legal_ops[2] = c_op_rtype;
        legal_ops[3] = c_op_itype; legal_ops[4] = c_op_jal;   legal_ops[5] = c_op_beq;

        rst = 1'b1; mem_ready = 1'b0; Zero = 1'b0;
        Op = 7'h00; funct3 = 3'b000; funct7 = 7'h00;

        // Directed scenarios
        add_instr(c_op_rtype, 3'b000, 7'h00, 0, 0, 1'b0, 0);   // add
        add_instr(c_op_rtype, 3'b000, 7'h20, 0, 0, 1'b0, 0);   // sub
        add_instr(c_op_itype, 3'b000, 7'h20, 0, 0, 1'b0, 0);   // addi, funct7[5] set
        add_instr(c_op_load,  3'b010, 7'h00, 0, 2, 1'b0, 0);   // lw, 2 stalls
        add_instr(c_op_beq,   3'b000, 7'h00, 0, 0, 1'b1, 0);   // taken
        add_instr(c_op_beq,   3'b000, 7'h00, 0, 0, 1'b0, 0);   // not taken
        add_instr(c_op_jal,   3'b000, 7'h00, 0, 0, 1'b0, 0);
        add_instr(c_op_store, 3'b010, 7'h00, 1, 1, 1'b0, 0);
        add_instr(c_op_rtype, 3'b111, 7'h00, 0, 0, 1'b0, 0);   // and
        add_instr(c_op_itype, 3'b110, 7'h00, 0, 0, 1'b0, 0);   // ori
        add_instr(c_op_rtype, 3'b010, 7'h00, 0, 0, 1'b0, 0);   // slt
        add_instr(7'b1111111, 3'b000, 7'h00, 0, 0, 1'b0, 5);   // trap
        add_sw_reset();

        // Random mix
        for (int i = 0; i < 80; i++) begin
            logic [6:0] op;
            if ($urandom_range(0, 9) == 0)
                op = ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'b0000000;
            else
                op = legal_ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 15) == 0)
                add_sw_reset();
            else
                add_instr(op, 3'($urandom_range(0, 7)), 7'($urandom), $urandom_range(0, 2),
                          $urandom_range(0, 2), rb(), $urandom_range(1, 3));
        end

        @(posedge clk);
        for (int c = 0; q.size() > 0; c++) begin
            step_t s;
            s = q.pop_front();
            @(posedge clk);
            #1;
            rst = s.rst; mem_ready = s.mr; Zero = s.z;
            Op = s.op; funct3 = s.f3; funct7 = s.f7;
            @(negedge clk);
            check($sformatf("cycle%0d_op%b", c, s.op),
                  {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ImmSrc, ALUControl, instr_done, illegal},
                  s.exp);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
